// File: rtl/music_pkg.sv
// music_pkg: note codes, sequencer states and the octave-10 phase increment table entry.
package music_pkg;
    localparam logic [7:0] NOTE_END = 8'd0;
    localparam logic [7:0] NOTE_REST = 8'd1;
    localparam logic [7:0] NOTE_MAX = 8'd127;
    typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;
    // Increment for MIDI note 120+s; lower octaves are derived by right shifts.
    function automatic longint note_inc(input int s, input int phase_w, input int fs_hz);
        real f;
        f = 440.0 * 2.0 ** (real'(51 + s) / 12.0);
        return longint'($rtoi(f * 2.0 ** phase_w / fs_hz + 0.5));
    endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control, ROM and tone bus of the note sequencer; carries tempo when SEQ_TEMPO_EN is defined.
interface note_sequencer_if #(parameter int ADDR_W = 9, parameter int PHASE_W = 24);
    logic start, stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0] rom_note;
    logic [PHASE_W-1:0] phase_inc;
    logic gate, busy, step, done;
    logic [7:0] note_out;
`ifdef SEQ_TEMPO_EN
    logic [23:0] tempo;
    modport master(input start, stop, rom_note, tempo, output rom_addr, phase_inc, gate, note_out, busy, step, done);
    modport slave(output start, stop, rom_note, tempo, input rom_addr, phase_inc, gate, note_out, busy, step, done);
`else
    modport master(input start, stop, rom_note, output rom_addr, phase_inc, gate, note_out, busy, step, done);
    modport slave(output start, stop, rom_note, input rom_addr, phase_inc, gate, note_out, busy, step, done);
`endif
endinterface

// File: rtl/note_sequencer_inc.sv
// note_to_inc: combinational MIDI note to phase increment (octave-10 table, shifted down by octave).
module note_to_inc import music_pkg::*; #(
    parameter int PHASE_W = 24,
    parameter int FS_HZ = 48000
) (
    input  logic [6:0]         note,
    output logic [PHASE_W-1:0] inc
);
    logic [PHASE_W-1:0] tbl [16];
    logic [3:0] oct, semi;
    for (genvar i = 0; i < 16; i++) begin : g_tbl
        assign tbl[i] = i < 12 ? PHASE_W'(note_inc(i, PHASE_W, FS_HZ)) : '0;
    end
    always_comb begin
        oct = 4'(note / 7'd12);
        semi = 4'(note % 7'd12);
        inc = tbl[semi] >> (4'd10 - oct);
    end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps a note ROM at a fixed tempo and drives gate/phase increment for a sine accumulator.
// Define SEQ_TEMPO_EN to take the step period from the tempo input, latched on start.
module note_sequencer import music_pkg::*; #(
    parameter int ADDR_W = 9,
    parameter int PHASE_W = 24,
    parameter int FS_HZ = 48000,
    parameter int TICK_CYCLES = 6250000,
    parameter int LOOP = 1
) (
    input logic clk,
    input logic rst_n,
    note_sequencer_if.master bus
);
    state_t state, state_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [PHASE_W-1:0] inc, inc_d, inc_new;
    logic [7:0] note, note_d;
    logic gate, gate_d, step, step_d, done, done_d, wrap, wrap_d, is_end, is_rest;
    logic [23:0] cnt, cnt_d, tick;
    note_to_inc #(.PHASE_W(PHASE_W), .FS_HZ(FS_HZ)) u_inc (.note(bus.rom_note[6:0]), .inc(inc_new));
`ifdef SEQ_TEMPO_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tick <= 24'(TICK_CYCLES);
        else if (state == IDLE && bus.start && !bus.stop) tick <= bus.tempo < 24'd4 ? 24'(TICK_CYCLES) : bus.tempo;
`else
    assign tick = 24'(TICK_CYCLES);
`endif
    // An address wrap out of the last entry ends the tune regardless of the fetched byte.
    assign is_end = wrap || bus.rom_note == NOTE_END || (bus.rom_note > NOTE_MAX && &addr);
    assign is_rest = bus.rom_note == NOTE_REST || bus.rom_note > NOTE_MAX;
    always_comb begin
        state_d = state;
        addr_d = addr;
        inc_d = inc;
        note_d = note;
        gate_d = gate;
        step_d = 1'b0;
        done_d = 1'b0;
        wrap_d = wrap;
        cnt_d = cnt;
        if (bus.stop) begin
            state_d = IDLE;
            addr_d = '0;
            inc_d = '0;
            gate_d = 1'b0;
            wrap_d = 1'b0;
            cnt_d = '0;
        end else case (state)
            IDLE: if (bus.start) begin
                state_d = FETCH;
                addr_d = '0;
                wrap_d = 1'b0;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                wrap_d = 1'b0;
                if (is_end) begin
                    addr_d = '0;
                    state_d = LOOP != 0 ? FETCH : IDLE;
                    done_d = LOOP == 0;
                    gate_d = LOOP != 0 && gate;
                    inc_d = LOOP != 0 ? inc : '0;
                end else begin
                    state_d = PLAY;
                    step_d = 1'b1;
                    cnt_d = '0;
                    gate_d = !is_rest;
                    note_d = is_rest ? note : bus.rom_note;
                    inc_d = is_rest ? inc : inc_new;
                end
            end
            PLAY: if (cnt == tick - 24'd3) begin
                state_d = FETCH;
                addr_d = addr + 1'b1;
                wrap_d = &addr;
            end else cnt_d = cnt + 24'd1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            inc <= '0;
            note <= '0;
            gate <= 1'b0;
            step <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_d;
            addr <= addr_d;
            inc <= inc_d;
            note <= note_d;
            gate <= gate_d;
            step <= step_d;
            done <= done_d;
            wrap <= wrap_d;
            cnt <= cnt_d;
        end
    assign bus.rom_addr = addr;
    assign bus.phase_inc = inc;
    assign bus.note_out = note;
    assign bus.gate = gate;
    assign bus.step = step;
    assign bus.done = done;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: three sequencers (tick 8 stop, tick 8 loop, tick 4 stop) checked against a tune-walking
// reference model that predicts each step pulse, its cycle offset and outputs, and the done pulse.
module tb_note_sequencer;
    localparam int ND = 3;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [7:0] rom [512];
    logic st [ND], sp [ND];
    logic [8:0] addr [ND];
    logic [23:0] pinc [ND];
    logic [7:0] nout [ND];
    logic gt [ND], bz [ND], stp [ND], dn [ND];
    for (genvar i = 0; i < ND; i++) begin : g_dut
        note_sequencer_if bus ();
        always @(posedge clk) bus.rom_note <= rom[bus.rom_addr];
        assign bus.start = st[i];
        assign bus.stop = sp[i];
`ifdef SEQ_TEMPO_EN
        assign bus.tempo = 24'd0;
`endif
        assign addr[i] = bus.rom_addr;
        assign pinc[i] = bus.phase_inc;
        assign nout[i] = bus.note_out;
        assign gt[i] = bus.gate;
        assign bz[i] = bus.busy;
        assign stp[i] = bus.step;
        assign dn[i] = bus.done;
        note_sequencer #(.TICK_CYCLES(i == 2 ? 4 : 8), .LOOP(i == 1 ? 1 : 0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end
    int checks = 0, errors = 0, cyc = 0, base = 0, sel = 0;
    int mnote [ND];
    int m_rel[$], m_gate[$], m_inc[$], m_note[$], m_addr[$], m_done[$];
    int e_rel[$], e_gate[$], e_inc[$], e_note[$], e_addr[$], e_done[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (stp[sel]) begin
            m_rel.push_back(cyc - base);
            m_gate.push_back(int'(gt[sel]));
            m_inc.push_back(int'(pinc[sel]));
            m_note.push_back(int'(nout[sel]));
            m_addr.push_back(int'(addr[sel]));
        end
        if (dn[sel]) m_done.push_back(cyc - base);
    end
    function automatic int tick_of(input int d);
        return d == 2 ? 4 : 8;
    endfunction
    function automatic int ref_inc(input int n);
        int s, o;
        real f;
        s = n % 12;
        o = n / 12;
        f = 440.0 * 2.0 ** (real'(120 + s - 69) / 12.0);
        return $rtoi(f * 16777216.0 / 48000.0 + 0.5) >> (10 - o);
    endfunction
    // Walk the tune: a sounded entry lasts one tick, a looping end marker costs 2 cycles.
    task automatic model(input int d, input int lim);
        int t, a, v, inc, note;
        bit wrapped;
        t = 2; a = 0; inc = 0; note = mnote[d]; wrapped = 0;
        e_rel.delete(); e_gate.delete(); e_inc.delete(); e_note.delete(); e_addr.delete(); e_done.delete();
        while (t < lim) begin
            v = int'(rom[a]);
            if (wrapped || v == 0 || (v > 127 && a == 511)) begin
                a = 0;
                wrapped = 0;
                if (d == 1) t += 2;
                else begin
                    e_done.push_back(t);
                    break;
                end
            end else begin
                if (v > 1 && v < 128) begin
                    note = v;
                    inc = ref_inc(v);
                end
                e_rel.push_back(t);
                e_gate.push_back(int'(v > 1 && v < 128));
                e_inc.push_back(inc);
                e_note.push_back(note);
                e_addr.push_back(a);
                t += tick_of(d);
                wrapped = a == 511;
                a = (a + 1) % 512;
            end
        end
        mnote[d] = note;
    endtask
    // Start dut d, stop it lim cycles after the start edge, then compare against the model.
    task automatic run(input string tag, input int d, input int lim);
        model(d, lim);
        m_rel.delete(); m_gate.delete(); m_inc.delete(); m_note.delete(); m_addr.delete(); m_done.delete();
        sel = d;
        @(negedge clk);
        st[d] = 1'b1;
        base = cyc + 1;
        @(negedge clk);
        st[d] = 1'b0;
        while (cyc < base + lim - 1) @(negedge clk);
        sp[d] = 1'b1;
        @(negedge clk);
        sp[d] = 1'b0;
        checks++;
        if (m_rel.size() !== e_rel.size()) begin
            errors++;
            $display("FAIL %s step_count: got %0d expected %0d", tag, m_rel.size(), e_rel.size());
        end
        for (int i = 0; i < e_rel.size() && i < m_rel.size(); i++) begin
            checks++;
            if (m_rel[i] !== e_rel[i] || m_gate[i] !== e_gate[i] || m_inc[i] !== e_inc[i] || m_note[i] !== e_note[i] || m_addr[i] !== e_addr[i]) begin
                errors++;
                $display("FAIL %s step%0d: got cyc %0d gate %0d inc %0d note %0d addr %0d, expected cyc %0d gate %0d inc %0d note %0d addr %0d",
                         tag, i, m_rel[i], m_gate[i], m_inc[i], m_note[i], m_addr[i], e_rel[i], e_gate[i], e_inc[i], e_note[i], e_addr[i]);
            end
        end
        checks++;
        if (m_done.size() !== e_done.size() || (e_done.size() == 1 && m_done[0] !== e_done[0])) begin
            errors++;
            $display("FAIL %s done: got %0d pulses (first %0d) expected %0d (at %0d)", tag, m_done.size(),
                     m_done.size() > 0 ? m_done[0] : -1, e_done.size(), e_done.size() > 0 ? e_done[0] : -1);
        end
        checks++;
        if (bz[d] !== 1'b0 || gt[d] !== 1'b0 || pinc[d] !== 24'd0 || addr[d] !== 9'd0 || int'(nout[d]) !== mnote[d]) begin
            errors++;
            $display("FAIL %s idle_after: got busy %0b gate %0b inc %0d addr %0d note %0d expected 0 0 0 0 note %0d",
                     tag, bz[d], gt[d], pinc[d], addr[d], nout[d], mnote[d]);
        end
    endtask
    task automatic fill(input int v);
        for (int a = 0; a < 512; a++) rom[a] = 8'(v);
    endtask
    task automatic test_reset();
        fill(0);
        for (int d = 0; d < ND; d++) begin
            st[d] = 1'b0;
            sp[d] = 1'b0;
            mnote[d] = 0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (bz[d] !== 0 || gt[d] !== 0 || pinc[d] !== 0 || addr[d] !== 0 || nout[d] !== 0 || stp[d] !== 0 || dn[d] !== 0) begin
                errors++;
                $display("FAIL reset dut%0d: got busy %0b gate %0b inc %0d addr %0d note %0d step %0b done %0b, expected all 0",
                         d, bz[d], gt[d], pinc[d], addr[d], nout[d], stp[d], dn[d]);
            end
        end
        rst_n = 1'b1;
    endtask
    task automatic test_directed();
        fill(0);
        rom[0] = 8'd69; rom[1] = 8'd69; rom[2] = 8'd1;
        run("tune_once", 0, 40);
        checks++;
        if (m_inc.size() == 0 || m_inc[0] !== 153791) begin
            errors++;
            $display("FAIL inc69: got %0d expected 153791", m_inc.size() > 0 ? m_inc[0] : -1);
        end
        run("tune_loop", 1, 70);
        fill(0);
        rom[0] = 8'd60; rom[1] = 8'd127; rom[2] = 8'd128; rom[3] = 8'd2;
        run("tune_mixed", 0, 50);
        checks++;
        if (m_inc.size() == 0 || m_inc[0] !== 91444) begin
            errors++;
            $display("FAIL inc60: got %0d expected 91444", m_inc.size() > 0 ? m_inc[0] : -1);
        end
        run("tune_mixed_fast", 2, 40);
    endtask
    task automatic test_stop();
        fill(69);
        run("stop_mid_play", 0, 13);
        run("stop_mid_loop", 1, 23);
        @(negedge clk);
        st[0] = 1'b1;
        sp[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        sp[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bz[0] !== 1'b0 || stp[0] !== 1'b0) begin
                errors++;
                $display("FAIL start_stop_idle cyc%0d: got busy %0b step %0b expected 0 0", i, bz[0], stp[0]);
            end
            @(negedge clk);
        end
    endtask
    task automatic test_reset_mid_play();
        fill(72);
        @(negedge clk);
        st[0] = 1'b1;
        st[1] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        st[1] = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (bz[d] !== 0 || gt[d] !== 0 || pinc[d] !== 0 || addr[d] !== 0 || nout[d] !== 0 || stp[d] !== 0 || dn[d] !== 0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: got busy %0b gate %0b inc %0d addr %0d note %0d step %0b done %0b, expected all 0",
                         d, bz[d], gt[d], pinc[d], addr[d], nout[d], stp[d], dn[d]);
            end
            mnote[d] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        rom[2] = 8'd1;
        rom[4] = 8'd0;
        run("replay_after_reset", 0, 45);
        run("replay_loop_after_reset", 1, 45);
    endtask
    task automatic test_random();
        int r;
        for (int k = 0; k < 8; k++) begin
            for (int a = 0; a < 512; a++) begin
                r = int'($urandom_range(0, 15));
                rom[a] = r == 0 ? 8'd0 : r < 3 ? 8'd1 : r < 5 ? 8'($urandom_range(128, 255)) : 8'($urandom_range(2, 127));
            end
            run($sformatf("random%0d", k), k % ND, int'($urandom_range(20, 250)));
        end
    endtask
    task automatic test_wrap();
        fill(61);
        run("wrap_all_61", 2, 2070);
        checks++;
        if (m_rel.size() !== 512) begin
            errors++;
            $display("FAIL wrap_512_steps: got %0d expected 512", m_rel.size());
        end
        rom[511] = 8'd200;
        run("last_addr_high_end", 2, 2070);
    endtask
    initial begin
        test_reset();
        test_directed();
        test_stop();
        test_reset_mid_play();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Sits upstream of the 9-bit-address / 8-bit-note music ROM and drives its address.
- Steps through the ROM at a fixed tempo and interprets each note byte: 0 = end of tune, 1 = rest, 2..127 = MIDI note.
- Converts each MIDI note to a phase increment for the downstream sine phase accumulator.
- Also produces the gate and status strobes.

Parameters:
- ADDR_W, 9, ROM address width.
- PHASE_W, 24, phase increment width.
- FS_HZ, 48000, sample rate of the downstream accumulator; used to build the increment table.
- TICK_CYCLES, 6250000, clock cycles per ROM step; must be at least 4.
- LOOP, 1, 1 = restart at address 0 on end marker; 0 = stop.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin playback from address 0.
- stop  in  1  one-cycle request to abort playback.
- rom_addr  out  ADDR_W  address to the note ROM.
- rom_note  in  8  ROM data, valid one clock after rom_addr is presented.
- phase_inc  out  PHASE_W  increment for the sine accumulator.
- gate  out  1  1 = sound the current note.
- note_out  out  8  last sounded MIDI note.
- busy  out  1  high whenever the state is not IDLE.
- step  out  1  one-cycle pulse when a new ROM entry takes effect.
- done  out  1  one-cycle pulse when a non-looping tune ends.

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; rom_addr, phase_inc and note_out = 0; gate, busy, step and done = 0; tick counter = 0.
- States: IDLE, FETCH, LATCH, PLAY.
- IDLE:
  - start -> rom_addr = 0, go to FETCH.
  - start is ignored when not in IDLE.
- FETCH: one cycle; the ROM registers its data. Go to LATCH.
- LATCH: decode rom_note.
  - 0, or 128..255 when rom_addr is the last address: treat as end marker.
    - LOOP=1: rom_addr = 0, go to FETCH; no step pulse; the end marker costs 2 cycles.
    - LOOP=0: done pulses, gate = 0, phase_inc = 0, rom_addr = 0, go to IDLE.
  - 1, or 128..255 (not at the last address): rest.
    - gate = 0; phase_inc and note_out hold; step pulses; go to PLAY.
  - 2..127: gate = 1, note_out = rom_note, phase_inc = INC(rom_note); step pulses; go to PLAY.
- PLAY:
  - Tick counter runs TICK_CYCLES-2 cycles.
  - On expiry, rom_addr increments and the state goes to FETCH.
  - When the increment wraps from all-ones to 0, the next LATCH treats the entry as an end marker.
  - Result: successive step pulses are exactly TICK_CYCLES cycles apart.
- INC(n): s = n mod 12, o = n / 12, INC = NOTE_INC[s] >> (10 - o).
  - NOTE_INC[s] = floor(f(120+s) * 2^PHASE_W / FS_HZ + 0.5), with f(m) = 440 * 2^((m-69)/12).
  - Check values: INC(69) = 153791; INC(60) = 91444.
- stop:
  - In any non-IDLE state: next cycle IDLE, gate = 0, phase_inc = 0, rom_addr = 0, no done pulse.
  - stop and start in the same cycle: stop wins, state stays IDLE.
- A reset during playback takes effect immediately; no pulses are emitted.
- All outputs are registered.

Optional Feature:
- Macro: SEQ_TEMPO_EN.
- Defined:
  - Adds input tempo [23:0].
  - tempo is latched on an accepted start and replaces TICK_CYCLES for that run.
  - Latched values below 4 select TICK_CYCLES.
- Undefined: no port; TICK_CYCLES is fixed.

Decomposition:
- Package music_pkg holds:
  - NOTE_END = 0, NOTE_REST = 1, NOTE_MAX = 127.
  - The state enum.
  - The NOTE_INC[0:11] constant function of PHASE_W and FS_HZ.
- Sub-module note_to_inc: combinational MIDI note -> phase increment (divide/mod by 12, table lookup, shift). It is registered by the sequencer in LATCH.

Test Plan:
- TICK_CYCLES=8, LOOP=0, ROM {69,69,1,0}, 1-cycle ROM model, pulse start:
  - Steps 1-2: step every 8 cycles, gate=1, phase_inc=153791, note_out=69.
  - Step 3: gate=0, phase_inc held.
  - Then done pulses once, busy=0, rom_addr=0.
- Same ROM, LOOP=1: after the end marker rom_addr returns to 0; next step 10 cycles after the previous one; the sequence repeats; done never pulses.
- ROM {60,127,128,2,0}:
  - phase_inc = 91444, then NOTE_INC[7].
  - 128 acts as a rest.
  - Note 2 gives NOTE_INC[2] >> 10.
- stop mid-PLAY: next cycle gate=0, phase_inc=0, busy=0, no done. start+stop together in IDLE: remains IDLE.
- rst_n low mid-PLAY: all outputs zero immediately; a fresh start replays from address 0.
- ROM of all 61 with TICK_CYCLES=4, LOOP=0: 512 step pulses, then wrap treated as end, done pulses.
